// File: rtl/ccd_frame_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ccd_frame_scheduler
// Brief    : Linear-CCD frame scheduler: SH/ICG sequencing, pixel indexing,
//            overrun detection. Define CCD_DARK_SUB_EN for dark subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module ccd_frame_scheduler #(
    parameter int NPIX   = 3694,
    parameter int MIN_SH = 10,
    parameter int DEF_SH = 100
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        cont_mode,
    input  logic [15:0] int_time,
    input  logic        icg_in,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,
    output logic [15:0] sh_pulse,
    output logic        pix_valid,
    output logic [11:0] pix_data,
    output logic [11:0] pix_idx,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT_ICG = 3'd2;
    localparam logic [2:0] S_READOUT  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [11:0] c_LAST_IDX = 12'(NPIX - 1);
    localparam logic [15:0] c_MIN_SH   = 16'(MIN_SH);
    localparam logic [15:0] c_DEF_SH   = 16'(DEF_SH);

    logic [2:0]  r_state;
    logic        r_icg_d;
    logic        r_cont;
    logic [11:0] r_cnt;

    logic        w_icg_rise;
    logic        w_restart;
    logic        w_enter_readout;
    logic [11:0] w_idx;
    logic [15:0] w_sh_load;
    logic [11:0] w_pix_out;

    assign w_icg_rise      = icg_in & ~r_icg_d;
    assign w_sh_load       = (int_time < c_MIN_SH) ? c_MIN_SH : int_time;
    // An ICG edge inside READOUT restarts the frame; a coincident strobe becomes pixel 0.
    assign w_restart       = (r_state == S_READOUT) && w_icg_rise;
    assign w_enter_readout = ((r_state == S_WAIT_ICG) && w_icg_rise) || w_restart;
    assign w_idx           = w_restart ? 12'd0 : r_cnt;

`ifdef CCD_DARK_SUB_EN
    logic [15:0] r_dark_sum;
    logic [11:0] w_dark;

    // Sum is final once pixel 31 is in; only pixels >= 32 consume it.
    assign w_dark    = r_dark_sum[15:4];
    assign w_pix_out = (w_idx < 12'd32)    ? adc_data :
                       (adc_data > w_dark) ? (adc_data - w_dark) : 12'd0;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_dark_sum <= 16'd0;
        end else if (w_enter_readout) begin
            r_dark_sum <= 16'd0;
        end else if ((r_state == S_READOUT) && adc_valid && (w_idx[11:4] == 8'd1)) begin
            r_dark_sum <= r_dark_sum + {4'd0, adc_data};
        end
    end
`else
    assign w_pix_out = adc_data;
`endif

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_icg_d    <= 1'b0;
            r_cont     <= 1'b0;
            r_cnt      <= 12'd0;
            sh_pulse   <= c_DEF_SH;
            pix_valid  <= 1'b0;
            pix_data   <= 12'd0;
            pix_idx    <= 12'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_icg_d    <= icg_in;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (stop) begin
                r_cont <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        sh_pulse <= w_sh_load;
                        r_cont   <= cont_mode & ~stop;
                        overrun  <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_icg_rise) begin
                        r_state <= S_WAIT_ICG;
                    end
                end
                S_WAIT_ICG: begin
                    if (w_icg_rise) begin
                        r_cnt   <= 12'd0;
                        pix_idx <= 12'd0;
                        r_state <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (w_icg_rise) begin
                        overrun <= 1'b1;
                        r_cnt   <= 12'd0;
                        pix_idx <= 12'd0;
                    end
                    if (adc_valid) begin
                        pix_valid <= 1'b1;
                        pix_data  <= w_pix_out;
                        pix_idx   <= w_idx;
                        r_cnt     <= w_idx + 12'd1;
                        if (w_idx == c_LAST_IDX) begin
                            frame_done <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_cont && !stop) begin
                        r_state <= S_ARM;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccd_frame_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ccd_frame_scheduler
// Brief    : Scoreboard bench for ccd_frame_scheduler (both dark-sub builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccd_frame_scheduler;

    localparam int c_NPIX = 3694;

    logic        clk_50m = 1'b0;
    logic        rst, start, stop, cont_mode, icg_in, adc_valid;
    logic [15:0] int_time;
    logic [11:0] adc_data;
    logic [15:0] sh_pulse;
    logic        pix_valid, frame_done, busy, overrun;
    logic [11:0] pix_data, pix_idx;

    typedef struct packed {
        logic [11:0] idx;
        logic [11:0] data;
        logic        done;
    } pix_t;

    pix_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_done  = 0;

    ccd_frame_scheduler dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cont_mode (cont_mode),
        .int_time  (int_time),
        .icg_in    (icg_in),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .sh_pulse  (sh_pulse),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_idx   (pix_idx),
        .frame_done(frame_done),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pixels 16..31 carry a flat 200 dark level; 40/41 are the subtraction probes.
    function automatic logic [11:0] adc_pattern(int i);
        if (i >= 16 && i <= 31) return 12'd200;
        if (i == 40) return 12'd150;
        if (i == 41) return 12'd500;
        return 12'((i * 37 + 5) % 4096);
    endfunction

    function automatic logic [11:0] exp_pix(int i);
        logic [11:0] d;
        d = adc_pattern(i);
`ifdef CCD_DARK_SUB_EN
        if (i >= 32) return (d > 12'd200) ? (d - 12'd200) : 12'd0;
`endif
        return d;
    endfunction

    always @(negedge clk_50m) begin
        if (pix_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pix_idx", int'(pix_idx), -1);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                check("pix_idx", int'(pix_idx), int'(e.idx));
                check("pix_data", int'(pix_data), int'(e.data));
                check("frame_done", int'(frame_done), int'(e.done));
            end
        end else if (frame_done) begin
            check("done_without_pix", int'(frame_done), 0);
        end
        if (frame_done) n_done++;
    end

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic icg_edge();
        icg_in = 1'b1;
        step();
        icg_in = 1'b0;
        step();
    endtask

    task automatic do_start(logic cm, int it);
        int_time  = 16'(it);
        cont_mode = cm;
        start     = 1'b1;
        step();
        start     = 1'b0;
        cont_mode = 1'b0;
    endtask

    task automatic stray(int n);
        for (int k = 0; k < n; k++) begin
            adc_valid = 1'b1;
            adc_data  = 12'hABC;
            step();
        end
        adc_valid = 1'b0;
    endtask

    task automatic send_pixels(int first, int count, int stop_at);
        for (int i = first; i < first + count; i++) begin
            adc_valid = 1'b1;
            adc_data  = adc_pattern(i);
            stop      = (i == stop_at);
            exp_q.push_back('{idx: 12'(i), data: exp_pix(i), done: (i == c_NPIX - 1)});
            step();
            adc_valid = 1'b0;
            stop      = 1'b0;
            if (i % 5 == 4) step();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont_mode = 1'b0;
        icg_in = 1'b0; adc_valid = 1'b0; adc_data = 12'd0; int_time = 16'd0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_sh_pulse", int'(sh_pulse), 100);
        check("rst_pix_idx", int'(pix_idx), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_overrun", int'(overrun), 0);

        // int_time below MIN_SH clamps
        do_start(1'b0, 5);
        check("min_sh_pulse", int'(sh_pulse), 10);
        check("min_sh_busy", int'(busy), 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_busy", int'(busy), 0);

        // Single frame: flush edge, then full readout
        do_start(1'b0, 300);
        stray(3);
        do_start(1'b1, 999);
        check("start_ignored_sh", int'(sh_pulse), 300);
        icg_edge();
        icg_edge();
        check("readout_busy", int'(busy), 1);
        send_pixels(0, c_NPIX, -1);
        repeat (3) step();
        check("single_done_cnt", n_done, 1);
        check("single_idle_busy", int'(busy), 0);
        check("single_q_empty", exp_q.size(), 0);

        // Continuous mode, stop during frame 2
        d0 = n_done;
        do_start(1'b1, 50);
        icg_edge();
        icg_edge();
        send_pixels(0, c_NPIX, -1);
        step();
        check("cont_rearm_busy", int'(busy), 1);
        check("cont_sh_f1", int'(sh_pulse), 50);
        icg_edge();
        icg_edge();
        send_pixels(0, c_NPIX, 100);
        repeat (3) step();
        check("cont_done_cnt", n_done - d0, 2);
        check("cont_idle_busy", int'(busy), 0);
        check("cont_sh_end", int'(sh_pulse), 50);
        icg_edge();
        icg_edge();
        stray(10);
        check("cont_no_frame3", n_done - d0, 2);

        // Overrun: ICG edge after pixel 1000, coincident strobe is pixel 0
        d0 = n_done;
        do_start(1'b0, 300);
        icg_edge();
        icg_edge();
        send_pixels(0, 1001, -1);
        icg_in = 1'b1;
        send_pixels(0, 1, -1);
        icg_in = 1'b0;
        check("overrun_set", int'(overrun), 1);
        check("overrun_no_done", n_done - d0, 0);
        send_pixels(1, c_NPIX - 1, -1);
        repeat (3) step();
        check("overrun_done_cnt", n_done - d0, 1);
        check("overrun_sticky", int'(overrun), 1);

        // Reset mid-readout, overriding start and adc_valid
        d0 = n_done;
        do_start(1'b0, 300);
        check("start_clears_overrun", int'(overrun), 0);
        icg_edge();
        icg_edge();
        send_pixels(0, 2000, -1);
        rst = 1'b1; adc_valid = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; adc_valid = 1'b0; start = 1'b0;
        check("midrst_pix_valid", int'(pix_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pix_idx", int'(pix_idx), 0);
        check("midrst_pix_data", int'(pix_data), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_sh_pulse", int'(sh_pulse), 100);
        repeat (3) step();
        check("midrst_no_done", n_done - d0, 0);
        check("midrst_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccd_frame_scheduler.md
CCD_FRAME_SCHEDULER -- requirements
Module: ccd_frame_scheduler

Interface
REQ-001 SHALL have parameter NPIX, default 3694, pixels (ADC strobes) per frame.
REQ-002 SHALL have parameter MIN_SH, default 10, minimum legal sh_pulse value.
REQ-003 SHALL have parameter DEF_SH, default 100, sh_pulse value after reset.
REQ-004 SHALL have port clk_50m  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse: load int_time, begin acquisition.
REQ-007 SHALL have port stop  in  1  one-cycle pulse: end continuous mode after the current frame.
REQ-008 SHALL have port cont_mode  in  1  sampled at start: 1 = repeat frames.
REQ-009 SHALL have port int_time  in  16  requested integration, SH periods.
REQ-010 SHALL have port icg_in  in  1  ICG line from the CCD timing generator.
REQ-011 SHALL have port adc_valid  in  1  one-cycle strobe per converted pixel.
REQ-012 SHALL have port adc_data  in  12  pixel sample, valid with adc_valid.
REQ-013 SHALL have port sh_pulse  out  16  SH period to the CCD timing generator.
REQ-014 SHALL have ports pix_valid/pix_data[11:0]/pix_idx[11:0]  out  pixel stream.
REQ-015 SHALL have ports frame_done, busy, overrun  out  1 each  status.

Function
REQ-016 SHALL implement the states IDLE, ARM, WAIT_ICG, READOUT and DONE.
REQ-017 IDLE + start SHALL load sh_pulse = max(int_time, MIN_SH), latch cont_mode, clear overrun, and enter ARM next cycle.
REQ-018 sh_pulse SHALL change only on the IDLE->ARM or DONE->ARM transition and SHALL hold constant otherwise.
REQ-019 icg rising edge SHALL mean icg_in=1 this cycle with its registered copy 0; one-cycle detect latency.
REQ-020 ARM SHALL discard the first icg rising edge (flush frame, no pixels output) and then enter WAIT_ICG.
REQ-021 WAIT_ICG SHALL enter READOUT on the next icg rising edge with pix_idx = 0.
REQ-022 In READOUT, each adc_valid SHALL produce pix_valid=1 one cycle later, with pix_data = adc_data and pix_idx = pixel number; pix_idx SHALL increment after each pixel.
REQ-023 adc_valid SHALL be ignored outside READOUT.
REQ-024 The pixel with index NPIX-1 SHALL assert frame_done for one cycle, coincident with its pix_valid, and SHALL enter DONE.
REQ-025 DONE SHALL go to ARM when the latched cont_mode is 1 and no stop is pending; otherwise it SHALL go to IDLE; this takes one cycle.
REQ-026 stop SHALL clear the latched cont_mode in any state; the frame in progress SHALL complete.
REQ-027 An icg rising edge in READOUT before pixel NPIX-1 SHALL set overrun (sticky until next start) and restart READOUT with pix_idx = 0; no frame_done for the aborted frame.
REQ-028 adc_valid coincident with that icg edge SHALL be counted as pixel 0 of the new frame.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 rst SHALL force IDLE, sh_pulse = DEF_SH, pix_idx = 0, pix_data = 0 and all 1-bit outputs = 0 on the next edge, overriding any other input.
REQ-032 rst mid-READOUT SHALL drop the frame without asserting frame_done.

Configuration
REQ-033 With macro CCD_DARK_SUB_EN defined, the block SHALL sum pixels 16..31 of each frame into a dark level = sum>>4, and for pixel index >= 32 SHALL output pix_data = adc_data - dark, saturated at 0.
REQ-034 With CCD_DARK_SUB_EN defined, pixels 0..31 SHALL pass unmodified, and the dark level SHALL reset to 0 at each READOUT entry.
REQ-035 Without CCD_DARK_SUB_EN, pix_data SHALL always equal adc_data and no dark logic SHALL be synthesized; latency SHALL be identical in both builds.

Verification
REQ-036 Scenario: rst, then start with int_time=5 -> sh_pulse=10 (MIN_SH) and busy=1 in the cycle after.
REQ-037 Scenario: start, cont_mode=0, two icg edges, then 3694 adc_valid -> first edge flushed, pix_idx 0..3693, one frame_done with pixel 3693, then IDLE and busy=0.
REQ-038 Scenario: cont_mode=1, three frames, stop during frame 2 -> frame_done x2, then IDLE; sh_pulse constant throughout.
REQ-039 Scenario: icg edge after pixel 1000 -> overrun=1, pix_idx restarts at 0, no frame_done for that frame.
REQ-040 Scenario (CCD_DARK_SUB_EN): pixels 16..31 = 200, pixel 40 = 150, pixel 41 = 500 -> pix_data 0 and 300; without the macro -> 150 and 500.
REQ-041 Scenario: rst asserted at pixel 2000 -> next cycle IDLE, all outputs at reset values, no frame_done.
